// File: rtl/alu_uart_master.sv
// alu_uart_master
//   Host-side initiator for the UART ALU link. It takes one request
//   {A, B, OPC} and pushes it into the TX FIFO as three words in that
//   order. It then waits for a single result word from the RX FIFO and
//   returns it on a valid/ready response port. If no reply arrives in
//   time, it returns a timeout response instead.
//
// Ports
//   i_clock, i_reset          clock (rising edge), synchronous active-high reset
//   i_req_valid/o_req_ready   request handshake; i_req_a/b/opcode payload
//   o_rsp_valid/i_rsp_ready   response handshake; o_rsp_result, o_rsp_timeout
//   i_txff_full, o_txff_write, o_txff_data     TX FIFO push side
//   i_rxff_empty, i_rxff_data, o_rxff_read     RX FIFO pop side (FWFT)
//   o_busy                    high whenever a transaction is in flight
module alu_uart_master #(
   parameter int WORD_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic [WORD_WIDTH-1:0] i_req_a,
   input  logic [WORD_WIDTH-1:0] i_req_b,
   input  logic [WORD_WIDTH-1:0] i_req_opcode,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [WORD_WIDTH-1:0] o_rsp_result,
   output logic                  o_rsp_timeout,
   input  logic                  i_txff_full,
   output logic                  o_txff_write,
   output logic [WORD_WIDTH-1:0] o_txff_data,
   input  logic                  i_rxff_empty,
   input  logic [WORD_WIDTH-1:0] i_rxff_data,
   output logic                  o_rxff_read,
   output logic                  o_busy
);

   localparam int              CW       = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      SEND_A,
      SEND_B,
      SEND_OPC,
      WAIT_RES,
      RESP
   } state_t;

   state_t                state;
   logic [WORD_WIDTH-1:0] a_q;
   logic [WORD_WIDTH-1:0] b_q;
   logic [WORD_WIDTH-1:0] opc_q;
   logic [CW-1:0]         wait_cnt;
   logic                  sending;

   assign sending = (state == SEND_A) || (state == SEND_B) || (state == SEND_OPC);

   // The handshake strobes are gated by reset. This keeps them at zero
   // during reset, even though the state register is only cleared at
   // the next clock edge.
   always_comb begin
      o_busy       = !i_reset && (state != IDLE);
      o_req_ready  = !i_reset && (state == IDLE) && i_rxff_empty;
      // In IDLE, any RX word is stale and gets dropped. In WAIT_RES, the
      // RX word is the reply.
      o_rxff_read  = !i_reset && ((state == IDLE) || (state == WAIT_RES)) && !i_rxff_empty;
      o_txff_write = !i_reset && sending && !i_txff_full;
      case (state)
         SEND_B:   o_txff_data = b_q;
         SEND_OPC: o_txff_data = opc_q;
         default:  o_txff_data = a_q;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state         <= IDLE;
         a_q           <= '0;
         b_q           <= '0;
         opc_q         <= '0;
         wait_cnt      <= '0;
         o_rsp_valid   <= 1'b0;
         o_rsp_result  <= '0;
         o_rsp_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // A request is accepted only after the RX FIFO has been
               // drained, so any stale byte is cleared out first.
               if (i_rxff_empty && i_req_valid) begin
                  a_q   <= i_req_a;
                  b_q   <= i_req_b;
                  opc_q <= i_req_opcode;
                  state <= SEND_A;
               end
            end
            SEND_A: if (!i_txff_full) state <= SEND_B;
            SEND_B: if (!i_txff_full) state <= SEND_OPC;
            SEND_OPC: begin
               if (!i_txff_full) begin
                  wait_cnt <= '0;
                  state    <= WAIT_RES;
               end
            end
            WAIT_RES: begin
               // If a reply arrives in the last cycle, it takes priority
               // over the timeout.
               if (!i_rxff_empty) begin
                  o_rsp_result  <= i_rxff_data;
                  o_rsp_timeout <= 1'b0;
                  o_rsp_valid   <= 1'b1;
                  state         <= RESP;
               end else if (wait_cnt == CNT_LAST) begin
                  o_rsp_result  <= '0;
                  o_rsp_timeout <= 1'b1;
                  o_rsp_valid   <= 1'b1;
                  state         <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            RESP: begin
               if (i_rsp_ready) begin
                  o_rsp_valid <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_uart_master.sv
module tb_alu_uart_master;
   localparam int W  = 8;
   localparam int TO = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         i_reset, i_req_valid, o_req_ready, o_rsp_valid, i_rsp_ready, o_rsp_timeout;
   logic         i_txff_full, o_txff_write, i_rxff_empty, o_rxff_read, o_busy;
   logic [W-1:0] i_req_a, i_req_b, i_req_opcode, o_rsp_result, o_txff_data, i_rxff_data;

   alu_uart_master #(.WORD_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
      .i_clock(clk), .i_reset(i_reset),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_opcode(i_req_opcode),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
      .o_rsp_result(o_rsp_result), .o_rsp_timeout(o_rsp_timeout),
      .i_txff_full(i_txff_full), .o_txff_write(o_txff_write), .o_txff_data(o_txff_data),
      .i_rxff_empty(i_rxff_empty), .i_rxff_data(i_rxff_data), .o_rxff_read(o_rxff_read),
      .o_busy(o_busy)
   );

   int total = 0;
   int bad   = 0;

   // Desired inputs for the next cycle. They are applied at the falling edge.
   logic         reset_d = 1'b1, req_valid_d = 1'b0, rsp_ready_d = 1'b0, tx_full = 1'b0;
   logic [W-1:0] a_d = '0, b_d = '0, opc_d = '0;

   // Behavioural FIFOs: rx_q models the RX FIFO, and tx_log records every
   // word pushed into the TX FIFO.
   logic [W-1:0] rx_q[$];
   logic [W-1:0] tx_log[$];

   // What was observed in the most recent cycle.
   logic         ev_acc, ev_write, ev_read, rsp_v, rsp_t, busy_o, rdy_o;
   logic [W-1:0] rsp_r;
   int           n_reads, rdy_viol;

   // One clock cycle. Inputs are applied at the falling edge. Outputs are
   // sampled 1ns later, and the FIFO models are updated for the rising edge
   // that follows.
   task automatic step();
      @(negedge clk);
      i_reset      = reset_d;
      i_req_valid  = req_valid_d;
      i_req_a      = a_d;
      i_req_b      = b_d;
      i_req_opcode = opc_d;
      i_rsp_ready  = rsp_ready_d;
      i_txff_full  = tx_full;
      i_rxff_empty = (rx_q.size() == 0);
      i_rxff_data  = (rx_q.size() == 0) ? '0 : rx_q[0];
      #1;
      ev_acc   = i_req_valid && o_req_ready;
      ev_write = o_txff_write;
      ev_read  = o_rxff_read;
      rsp_v    = o_rsp_valid;
      rsp_r    = o_rsp_result;
      rsp_t    = o_rsp_timeout;
      busy_o   = o_busy;
      rdy_o    = o_req_ready;
      if (o_txff_write) tx_log.push_back(o_txff_data);
      if (o_rxff_read && rx_q.size() != 0) begin
         void'(rx_q.pop_front());
         n_reads++;
      end
      if (o_rxff_read && o_req_ready) rdy_viol++;
   endtask

   // Drives one full transaction and reports the cycle indices seen, counted
   // from the first request cycle (k=0). The reply word is made visible
   // reply_d cycles after WAIT_RES is entered (reply_d < 0 means no reply).
   task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] opc,
                         input logic [W-1:0] reply, input int reply_d, input int full_pct,
                         input logic [63:0] full_mask, input int hold,
                         output int acc_k, output int wopc_k, output int rsp_k,
                         output logic [W-1:0] res, output logic to,
                         output bit stable, output bit idle_after);
      int k;
      k = 0; acc_k = -1; wopc_k = -1; rsp_k = -1; res = '0; to = 1'b0;
      stable = 1'b1; idle_after = 1'b0;
      tx_log.delete(); n_reads = 0; rdy_viol = 0;
      a_d = a; b_d = b; opc_d = opc; req_valid_d = 1'b1; rsp_ready_d = 1'b0;
      while (rsp_k < 0 && k < 300) begin
         tx_full = ((k < 64) ? full_mask[k[5:0]] : 1'b0) || (int'($urandom_range(99)) < full_pct);
         if (wopc_k >= 0 && reply_d >= 0 && k == wopc_k + 1 + reply_d) rx_q.push_back(reply);
         step();
         if (ev_acc) begin acc_k = k; req_valid_d = 1'b0; end
         if (ev_write && tx_log.size() == 3 && wopc_k < 0) wopc_k = k;
         if (rsp_v) begin rsp_k = k; res = rsp_r; to = rsp_t; end
         k++;
      end
      tx_full = 1'b0;
      for (int h = 0; h < hold; h++) begin
         step();
         if (!rsp_v || rsp_r !== res || rsp_t !== to) stable = 1'b0;
      end
      rsp_ready_d = 1'b1; step(); if (!rsp_v) stable = 1'b0;
      rsp_ready_d = 1'b0; step(); idle_after = !busy_o && !rsp_v;
   endtask

   int acc_k, wopc_k, rsp_k;
   logic [W-1:0] res;
   logic to;
   bit stable, idle_after;

   task automatic test_reset();
      reset_d = 1'b1; rx_q.push_back(8'h5A); step();
      total++;
      if ({busy_o, rdy_o, ev_write, ev_read} !== 4'b0000) begin
         bad++; $display("FAIL reset_comb got busy/rdy/wr/rd=%b exp=0000", {busy_o, rdy_o, ev_write, ev_read});
      end
      step();
      total++;
      if ({rsp_v, rsp_t, rsp_r} !== '0) begin
         bad++; $display("FAIL reset_regs got v=%b t=%b r=%h exp 0", rsp_v, rsp_t, rsp_r);
      end
      rx_q.delete(); reset_d = 1'b0; step();
      total++;
      if (rdy_o !== 1'b1 || busy_o !== 1'b0) begin
         bad++; $display("FAIL reset_idle got rdy=%b busy=%b exp rdy=1 busy=0", rdy_o, busy_o);
      end
   endtask

   task automatic test_basic();
      do_txn(8'h05, 8'h03, 8'h20, 8'h08, 0, 0, 64'h0, 0, acc_k, wopc_k, rsp_k, res, to, stable, idle_after);
      total++;
      if (tx_log.size() != 3 || {tx_log[0], tx_log[1], tx_log[2]} !== 24'h050320) begin
         bad++; $display("FAIL basic_tx got n=%0d exp 05 03 20", tx_log.size());
      end
      total++;
      if (acc_k != 0 || wopc_k != 3 || rsp_k != 5) begin
         bad++; $display("FAIL basic_timing got acc=%0d opc=%0d rsp=%0d exp 0 3 5", acc_k, wopc_k, rsp_k);
      end
      total++;
      if (res !== 8'h08 || to !== 1'b0 || !idle_after) begin
         bad++; $display("FAIL basic_rsp got r=%h t=%b idle=%b exp 08 0 1", res, to, idle_after);
      end
   endtask

   task automatic test_backpressure();
      do_txn(8'h05, 8'h03, 8'h20, 8'h08, 0, 0, 64'h7C, 0, acc_k, wopc_k, rsp_k, res, to, stable, idle_after);
      total++;
      if (tx_log.size() != 3 || {tx_log[0], tx_log[1], tx_log[2]} !== 24'h050320) begin
         bad++; $display("FAIL bp_tx got n=%0d exp 3 words 05 03 20", tx_log.size());
      end
      total++;
      if (wopc_k != 8 || rsp_k != 10 || res !== 8'h08) begin
         bad++; $display("FAIL bp_timing got opc=%0d rsp=%0d r=%h exp 8 10 08", wopc_k, rsp_k, res);
      end
   endtask

   task automatic test_timeout();
      do_txn(8'h11, 8'h22, 8'h33, 8'hC3, -1, 0, 64'h0, 0, acc_k, wopc_k, rsp_k, res, to, stable, idle_after);
      total++;
      if (rsp_k != wopc_k + 1 + TO || res !== 8'h00 || to !== 1'b1) begin
         bad++; $display("FAIL timeout_fire got dt=%0d r=%h t=%b exp dt=%0d r=00 t=1", rsp_k - wopc_k, res, to, 1 + TO);
      end
      do_txn(8'h11, 8'h22, 8'h33, 8'hC3, TO - 1, 0, 64'h0, 0, acc_k, wopc_k, rsp_k, res, to, stable, idle_after);
      total++;
      if (rsp_k != wopc_k + 1 + TO || res !== 8'hC3 || to !== 1'b0) begin
         bad++; $display("FAIL timeout_last got dt=%0d r=%h t=%b exp dt=%0d r=c3 t=0", rsp_k - wopc_k, res, to, 1 + TO);
      end
      do_txn(8'h11, 8'h22, 8'h33, 8'hC4, TO, 0, 64'h0, 0, acc_k, wopc_k, rsp_k, res, to, stable, idle_after);
      total++;
      if (to !== 1'b1 || n_reads != 1 || rx_q.size() != 0) begin
         bad++; $display("FAIL timeout_late got t=%b reads=%0d left=%0d exp 1 1 0", to, n_reads, rx_q.size());
      end
   endtask

   task automatic test_stale();
      rx_q.push_back(8'hAA); rx_q.push_back(8'hBB);
      do_txn(8'h01, 8'h02, 8'h03, 8'h5E, 0, 0, 64'h0, 0, acc_k, wopc_k, rsp_k, res, to, stable, idle_after);
      total++;
      if (acc_k != 2 || rdy_viol != 0 || n_reads != 3 || res !== 8'h5E) begin
         bad++; $display("FAIL stale got acc=%0d viol=%0d reads=%0d r=%h exp 2 0 3 5e", acc_k, rdy_viol, n_reads, res);
      end
   endtask

   task automatic test_hold();
      do_txn(8'h7F, 8'h80, 8'h01, 8'hE7, 3, 0, 64'h0, 10, acc_k, wopc_k, rsp_k, res, to, stable, idle_after);
      total++;
      if (!stable || !idle_after || res !== 8'hE7) begin
         bad++; $display("FAIL hold got stable=%b idle=%b r=%h exp 1 1 e7", stable, idle_after, res);
      end
   endtask

   task automatic test_reset_midop();
      tx_log.delete();
      a_d = 8'h11; b_d = 8'h22; opc_d = 8'h33; req_valid_d = 1'b1; step();
      req_valid_d = 1'b0; step();
      reset_d = 1'b1; step();
      total++;
      if (busy_o !== 1'b0 || ev_write !== 1'b0 || rdy_o !== 1'b0) begin
         bad++; $display("FAIL midrst_comb got busy=%b wr=%b rdy=%b exp 0 0 0", busy_o, ev_write, rdy_o);
      end
      reset_d = 1'b0; step();
      total++;
      if (rsp_v !== 1'b0 || busy_o !== 1'b0 || rdy_o !== 1'b1 || tx_log.size() != 1) begin
         bad++; $display("FAIL midrst_idle got v=%b busy=%b rdy=%b txn=%0d exp 0 0 1 1", rsp_v, busy_o, rdy_o, tx_log.size());
      end
      rx_q.push_back(8'h99);
      do_txn(8'h44, 8'h55, 8'h66, 8'h77, 1, 0, 64'h0, 0, acc_k, wopc_k, rsp_k, res, to, stable, idle_after);
      total++;
      if (acc_k != 1 || n_reads != 2 || res !== 8'h77 || to !== 1'b0 ||
          tx_log.size() != 3 || {tx_log[0], tx_log[1], tx_log[2]} !== 24'h445566) begin
         bad++; $display("FAIL midrst_next got acc=%0d reads=%0d r=%h t=%b exp 1 2 77 0", acc_k, n_reads, res, to);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 40; it++) begin
         logic [W-1:0] a, b, opc, rep, exp_r;
         int d, pend, hold, exp_k;
         bit ok;
         a = W'($urandom); b = W'($urandom); opc = W'($urandom); rep = W'($urandom);
         for (int s = int'($urandom_range(2)); s > 0; s--) rx_q.push_back(W'($urandom));
         pend = rx_q.size();
         d = int'($urandom_range(19));
         if (d > TO) d = -1;
         hold = int'($urandom_range(3));
         do_txn(a, b, opc, rep, d, 30, 64'h0, hold, acc_k, wopc_k, rsp_k, res, to, stable, idle_after);
         ok    = (d >= 0 && d < TO);
         exp_r = ok ? rep : '0;
         exp_k = ok ? wopc_k + 2 + d : wopc_k + 1 + TO;
         total++;
         if (tx_log.size() != 3 || {tx_log[0], tx_log[1], tx_log[2]} !== {a, b, opc} || acc_k != pend) begin
            bad++; $display("FAIL rnd_req it=%0d n=%0d acc=%0d exp acc=%0d %h %h %h", it, tx_log.size(), acc_k, pend, a, b, opc);
         end
         total++;
         if (wopc_k < 0 || rsp_k != exp_k || res !== exp_r || to !== !ok) begin
            bad++; $display("FAIL rnd_rsp it=%0d k=%0d r=%h t=%b exp k=%0d r=%h t=%b", it, rsp_k, res, to, exp_k, exp_r, !ok);
         end
         total++;
         if (n_reads != pend + (d >= 0 ? 1 : 0) || !stable || !idle_after || rdy_viol != 0) begin
            bad++; $display("FAIL rnd_misc it=%0d reads=%0d stable=%b idle=%b viol=%0d exp reads=%0d", it, n_reads, stable, idle_after, rdy_viol, pend + (d >= 0 ? 1 : 0));
         end
      end
   endtask

   initial begin
      i_reset = 1'b1; i_req_valid = 1'b0; i_rsp_ready = 1'b0; i_txff_full = 1'b0;
      i_rxff_empty = 1'b1; i_rxff_data = '0; i_req_a = '0; i_req_b = '0; i_req_opcode = '0;
      test_reset();
      test_basic();
      test_backpressure();
      test_timeout();
      test_stale();
      test_hold();
      test_reset_midop();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
